key_expander: RTL and testbench

KEY_EXPANDER -- requirements
Module: key_expander

---
 rtl/key_expander.sv | 174 +++++++++++++++++
 tb/tb_key_expander.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_expander.sv
// AES key expansion engine: streams round-key words w[0..Nw-1] over a valid/ready
// port, keeping only a sliding window of the last Nk words as key storage.
module key_expander #(
  parameter int MAX_NK = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [1:0]           mode,
  input  logic [32*MAX_NK-1:0] key,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic                 w_valid,
  input  logic                 w_ready,
  output logic [31:0]          w_data,
  output logic [5:0]           w_index
);

  typedef enum logic [2:0] {IDLE, KEYOUT, CALC, OUT, FIN} state_t;

  localparam logic [7:0] SBOX [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  state_t      state_reg, state_next;
  logic [31:0] window_reg [MAX_NK];
  logic [31:0] shift_src  [MAX_NK];
  logic [5:0]  idx_reg;
  logic [2:0]  pos_reg;
  logic [7:0]  rcon_reg;
  logic [3:0]  nk_reg;
  logic [5:0]  nw_last_reg;
  logic        err_reg;

  logic [3:0]  mode_nk;
  logic [5:0]  mode_nw_last;
  logic        mode_ok;
  logic        accept_start;
  logic        reject_start;
  logic        w_fire;
  logic        shift_en;
  logic [31:0] key_word;
  logic [31:0] last_word;
  logic [31:0] sbox_addr;
  logic [31:0] sub_word;
  logic [31:0] temp_word;
  logic [31:0] new_word;

  always_comb begin
    mode_nk      = 4'd4;
    mode_nw_last = 6'd43;
    case (mode)
      2'd1:    begin mode_nk = 4'd6; mode_nw_last = 6'd51; end
      2'd2:    begin mode_nk = 4'd8; mode_nw_last = 6'd59; end
      default: ;
    endcase
    mode_ok = (mode != 2'd3) && (int'(mode_nk) <= MAX_NK);
  end

  assign accept_start = (state_reg == IDLE) && start && mode_ok;
  assign reject_start = (state_reg == IDLE) && start && !mode_ok;
  assign w_valid      = (state_reg == KEYOUT) || (state_reg == OUT);
  assign w_fire       = w_valid && w_ready;
  assign shift_en     = (state_reg == OUT) && w_fire;
  assign busy         = (state_reg == KEYOUT) || (state_reg == CALC) || (state_reg == OUT);
  assign done         = (state_reg == FIN);
  assign err          = err_reg;

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept_start) state_next = KEYOUT;
      KEYOUT:  if (w_fire && idx_reg == 6'(nk_reg) - 6'd1) state_next = CALC;
      CALC:    state_next = OUT;
      OUT:     if (w_fire) state_next = (idx_reg == nw_last_reg) ? FIN : CALC;
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Window slot 0 is always w[i-Nk]; slot Nk-1 is always w[i-1].
  always_comb begin
    key_word  = '0;
    last_word = '0;
    for (int j = 0; j < MAX_NK; j++) begin
      if (j == int'(idx_reg)) key_word = window_reg[j];
      if (j == int'(nk_reg) - 1) last_word = window_reg[j];
    end
  end

  assign sbox_addr = (pos_reg == 3'd0) ? {last_word[7:0], last_word[31:8]} : last_word;

  // S-box lanes only load in CALC so the OUT word stays frozen through stalls.
  for (genvar gi = 0; gi < 4; gi++) begin : g_sbox
    logic [7:0] lane_q;
    always_ff @(posedge clk) begin
      if (state_reg == CALC) lane_q <= SBOX[sbox_addr[8*gi +: 8]];
    end
    assign sub_word[8*gi +: 8] = lane_q;
  end

  always_comb begin
    if (pos_reg == 3'd0)                         temp_word = sub_word ^ {24'h0, rcon_reg};
    else if (nk_reg == 4'd8 && pos_reg == 3'd4)  temp_word = sub_word;
    else                                         temp_word = last_word;
    new_word = window_reg[0] ^ temp_word;
  end

  for (genvar gi = 0; gi < MAX_NK; gi++) begin : g_shift
    if (gi < MAX_NK - 1) begin : g_mid
      assign shift_src[gi] = (gi == int'(nk_reg) - 1) ? new_word : window_reg[gi+1];
    end else begin : g_top
      assign shift_src[gi] = new_word;
    end
  end

  always_ff @(posedge clk) begin
    for (int j = 0; j < MAX_NK; j++) begin
      if (rst)               window_reg[j] <= '0;
      else if (accept_start) window_reg[j] <= key[32*j +: 32];
      else if (shift_en)     window_reg[j] <= shift_src[j];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_reg     <= '0;
      pos_reg     <= '0;
      rcon_reg    <= 8'h01;
      nk_reg      <= 4'd4;
      nw_last_reg <= 6'd43;
      err_reg     <= 1'b0;
    end else begin
      err_reg <= reject_start;
      if (accept_start) begin
        idx_reg     <= '0;
        pos_reg     <= '0;
        rcon_reg    <= 8'h01;
        nk_reg      <= mode_nk;
        nw_last_reg <= mode_nw_last;
      end else if (w_fire) begin
        idx_reg <= idx_reg + 6'd1;
        pos_reg <= (pos_reg == 3'(nk_reg - 4'd1)) ? 3'd0 : pos_reg + 3'd1;
        if (shift_en && pos_reg == 3'd0)
          rcon_reg <= {rcon_reg[6:0], 1'b0} ^ (rcon_reg[7] ? 8'h1b : 8'h00);
      end
    end
  end

  assign w_data  = (state_reg == KEYOUT) ? key_word : (state_reg == OUT) ? new_word : 32'h0;
  assign w_index = w_valid ? idx_reg : 6'd0;

endmodule

// File: tb/tb_key_expander.sv
// Self-checking bench for key_expander: FIPS-197 vectors, stalls, illegal starts,
// starts while busy / in FIN, and reset mid-expansion.
module tb_key_expander;
  logic         clk = 1'b0;
  logic         rst, start, w_ready;
  logic [1:0]   mode;
  logic [255:0] key;
  logic         busy, done, err, w_valid;
  logic [31:0]  w_data;
  logic [5:0]   w_index;

  int tests_run = 0;
  int tests_failed = 0;

  logic [7:0]  sb [256];
  logic [31:0] exp_w [60];
  logic [31:0] obs_w [64];
  logic [37:0] exp_q [$];

  localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  always #5 clk = ~clk;

  key_expander #(.MAX_NK(8)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .key(key),
    .busy(busy), .done(done), .err(err), .w_valid(w_valid), .w_ready(w_ready),
    .w_data(w_data), .w_index(w_index)
  );

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h0, x = a, y = b;
    for (int n = 0; n < 8; n++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  // S-box derived from GF(2^8) inversion plus the affine map, independent of the ROM table
  task automatic build_sbox();
    logic [7:0] inv, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      sb[x] = s;
    end
  endtask

  function automatic logic [255:0] pack_key(input logic [255:0] be);
    logic [255:0] r = '0;
    for (int b = 0; b < 32; b++) r[8*b +: 8] = be[255-8*b -: 8];
    return r;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] v);
    return {sb[v[31:24]], sb[v[23:16]], sb[v[15:8]], sb[v[7:0]]};
  endfunction

  function automatic void expand(input logic [255:0] k, input int nk);
    logic [7:0]  rc [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
    logic [31:0] t;
    for (int i = 0; i < 4*nk + 28; i++) begin
      if (i < nk) exp_w[i] = k[32*i +: 32];
      else begin
        t = exp_w[i-1];
        if (i % nk == 0) t = subw({t[7:0], t[31:8]}) ^ {24'h0, rc[i/nk - 1]};
        else if (nk == 8 && i % 8 == 4) t = subw(t);
        exp_w[i] = exp_w[i-nk] ^ t;
      end
    end
  endfunction

  // Pushes the model stream, pulses start, then scrambles key/mode.
  task automatic kick(input logic [1:0] m, input logic [255:0] k, input int nk);
    expand(k, nk);
    exp_q.delete();
    for (int i = 0; i < 4*nk + 28; i++) exp_q.push_back({6'(i), exp_w[i]});
    mode = m; key = k; start = 1'b1;
    @(negedge clk);
    start = 1'b0; mode = 2'd3; key = ~k;
    tests_run++;
    if ({busy, w_valid} !== 2'b11) begin
      tests_failed++;
      $display("FAIL first_valid: busy/w_valid=%b required 11", {busy, w_valid});
    end
  endtask

  task automatic drain(input int stall_pct, input int abort_at, input int poke_at, input bit fin_start,
                       output int words, output int dones, output int done_cyc);
    bit          prev_stall = 0, err_seen = 0;
    logic [31:0] held_d = '0;
    logic [5:0]  held_i = '0;
    logic [37:0] e;
    words = 0; dones = 0; done_cyc = -1;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      start = 1'b0;
      if (err) err_seen = 1;
      if (prev_stall) begin
        tests_run++;
        if ({w_valid, w_data, w_index} !== {1'b1, held_d, held_i}) begin
          tests_failed++;
          $display("FAIL stall_hold: valid/data/idx=%b/%08h/%0d required 1/%08h/%0d", w_valid, w_data, w_index, held_d, held_i);
        end
      end
      if (w_valid && abort_at >= 0 && int'(w_index) == abort_at) begin
        rst = 1'b1;
        @(negedge clk);
        tests_run++;
        if ({busy, done, err, w_valid, w_data, w_index} !== 42'h0) begin
          tests_failed++;
          $display("FAIL abort_outputs: busy/done/err/valid/data/idx=%b%b%b%b/%08h/%0d required all zero", busy, done, err, w_valid, w_data, w_index);
        end
        exp_q.delete();
        return;
      end
      w_ready = ($urandom_range(99) >= stall_pct);
      if (w_valid && poke_at >= 0 && int'(w_index) == poke_at) begin
        start = 1'b1; mode = 2'd2;
      end
      if (w_valid && w_ready) begin
        tests_run++;
        if (exp_q.size() == 0) begin
          tests_failed++;
          $display("FAIL extra_word: idx=%0d data=%08h required no word", w_index, w_data);
        end else begin
          e = exp_q.pop_front();
          if ({w_index, w_data} !== e) begin
            tests_failed++;
            $display("FAIL word: idx/data=%0d/%08h required %0d/%08h", w_index, w_data, e[37:32], e[31:0]);
          end
        end
        obs_w[w_index] = w_data;
        words++;
        $display("[TB] word idx=%0d data=%08h", w_index, w_data);
      end
      prev_stall = w_valid && !w_ready;
      held_d = w_data; held_i = w_index;
      if (done) begin
        dones++;
        if (done_cyc < 0) begin
          done_cyc = cyc;
          tests_run++;
          if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL busy_at_done: busy=%b required 0", busy);
          end
          if (fin_start) begin start = 1'b1; mode = 2'd0; end
        end
      end
      if (fin_start && done_cyc >= 0 && cyc == done_cyc + 1) begin
        tests_run++;
        if ({busy, w_valid} !== 2'b00) begin
          tests_failed++;
          $display("FAIL fin_start: busy/w_valid=%b required 00", {busy, w_valid});
        end
      end
      if (done_cyc >= 0 && cyc == done_cyc + 3) break;
      @(negedge clk);
    end
    tests_run++;
    if (err_seen) begin
      tests_failed++;
      $display("FAIL err_during_stream: err=1 required 0");
    end
  endtask

  task automatic check_run(input string name, input int words, input int nw, input int dones);
    tests_run++;
    if (words !== nw || dones !== 1) begin
      tests_failed++;
      $display("FAIL %s_count: words/dones=%0d/%0d required %0d/1", name, words, dones, nw);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; w_ready = 1'b0; mode = 2'd0; key = '0;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({busy, done, err, w_valid, w_data, w_index} !== 42'h0) begin
      tests_failed++;
      $display("FAIL reset_outputs: busy/done/err/valid/data/idx=%b%b%b%b/%08h/%0d required all zero", busy, done, err, w_valid, w_data, w_index);
    end
    rst = 1'b0;
    @(negedge clk);
    $display("[TB] reset released");
  endtask

  task automatic test_aes128();
    int words, dones, dc;
    kick(2'd0, pack_key(K128), 4);
    drain(0, -1, -1, 1'b0, words, dones, dc);
    check_run("aes128", words, 44, dones);
    tests_run++;
    if (obs_w[4] !== 32'h17FEFAA0 || obs_w[43] !== 32'hA60C63B6) begin
      tests_failed++;
      $display("FAIL aes128_vec: w4/w43=%08h/%08h required 17fefaa0/a60c63b6", obs_w[4], obs_w[43]);
    end
    // first valid is cycle 0: 4 key words at 1/cycle then 40 words at 2 cycles each
    tests_run++;
    if (dc !== 4 + 2*40) begin
      tests_failed++;
      $display("FAIL aes128_throughput: done at cycle %0d required %0d", dc, 4 + 2*40);
    end
  endtask

  task automatic test_aes192();
    int words, dones, dc;
    kick(2'd1, pack_key(K192), 6);
    drain(0, -1, -1, 1'b1, words, dones, dc);
    check_run("aes192", words, 52, dones);
    tests_run++;
    if (obs_w[6] !== 32'hF7910CFE || obs_w[51] !== 32'h02220001) begin
      tests_failed++;
      $display("FAIL aes192_vec: w6/w51=%08h/%08h required f7910cfe/02220001", obs_w[6], obs_w[51]);
    end
  endtask

  task automatic test_aes256_stalls();
    int words, dones, dc;
    kick(2'd2, pack_key(K256), 8);
    drain(40, -1, -1, 1'b0, words, dones, dc);
    check_run("aes256", words, 60, dones);
    tests_run++;
    if (obs_w[8] !== 32'h1154A39B || obs_w[59] !== 32'h1E636C70) begin
      tests_failed++;
      $display("FAIL aes256_vec: w8/w59=%08h/%08h required 1154a39b/1e636c70", obs_w[8], obs_w[59]);
    end
  endtask

  task automatic test_illegal();
    start = 1'b1; mode = 2'd3; key = pack_key(K128);
    @(negedge clk);
    start = 1'b0;
    tests_run++;
    if ({err, busy, w_valid} !== 3'b100) begin
      tests_failed++;
      $display("FAIL illegal_err: err/busy/valid=%b required 100", {err, busy, w_valid});
    end
    @(negedge clk);
    tests_run++;
    if ({err, busy, w_valid, w_data, w_index} !== 41'h0) begin
      tests_failed++;
      $display("FAIL illegal_after: err/busy/valid=%b data=%08h idx=%0d required zeros", {err, busy, w_valid}, w_data, w_index);
    end
    $display("[TB] illegal start checked");
  endtask

  task automatic test_busy_start();
    int words, dones, dc;
    kick(2'd0, pack_key(K128), 4);
    drain(20, -1, 10, 1'b0, words, dones, dc);
    check_run("busy_start", words, 44, dones);
  endtask

  task automatic test_reset_abort();
    int words, dones, dc;
    kick(2'd0, pack_key(K128), 4);
    drain(0, 20, -1, 1'b0, words, dones, dc);
    tests_run++;
    if (dones !== 0 || words !== 20) begin
      tests_failed++;
      $display("FAIL abort_stream: words/dones=%0d/%0d required 20/0", words, dones);
    end
    rst = 1'b0;
    kick(2'd0, pack_key(K128), 4);
    drain(0, -1, -1, 1'b0, words, dones, dc);
    check_run("restart", words, 44, dones);
  endtask

  initial begin
    build_sbox();
    test_reset();
    test_aes128();
    test_aes192();
    test_aes256_stalls();
    test_illegal();
    test_busy_start();
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
